l1i_mau: RTL and testbench

L1I_MAU -- requirements
Module: l1i_mau

---
 rtl/l1i_mau_pkg.sv | 26 ++
 rtl/l1i_mau_linebuf.sv | 30 +++
 rtl/l1i_mau.sv | 103 ++++++++++
 tb/tb_l1i_mau.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1i_mau_pkg.sv
// Shared L1 definitions: default geometry, miss-unit FSM states and the
// beat geometry helpers used by the fill path.
package l1i_mau_pkg;

    localparam int unsigned L1_ADDR_W = 32;
    localparam int unsigned L1_LINE_W = 128;
    localparam int unsigned L1_BUS_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mau_state_t;

    // Number of bus beats making up one cache line.
    function automatic int unsigned l1_nbeat(input int unsigned line_w, input int unsigned bus_w);
        return line_w / bus_w;
    endfunction

    // Byte distance between consecutive beat addresses.
    function automatic int unsigned l1_beat_stride(input int unsigned bus_w);
        return bus_w / 8;
    endfunction

endpackage

// File: rtl/l1i_mau_linebuf.sv
// Line assembly buffer: one bus word written per beat, whole line read out.
module l1i_mau_linebuf
    import l1i_mau_pkg::*;
#(
    parameter  int unsigned LINE_W = L1_LINE_W,
    parameter  int unsigned BUS_W  = L1_BUS_W,
    localparam int unsigned NBEAT  = l1_nbeat(LINE_W, BUS_W),
    localparam int unsigned BEAT_W = $clog2(NBEAT)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BEAT_W-1:0] wbeat,
    input  logic [BUS_W-1:0]  wdata,
    output logic [LINE_W-1:0] rdata
);

    // Datapath storage, deliberately not reset.
    logic [BUS_W-1:0] word_mem [NBEAT];

    always_ff @(posedge clk) begin
        if (we) begin
            word_mem[wbeat] <= wdata;
        end
    end

    for (genvar gi = 0; gi < NBEAT; gi++) begin : g_pack
        assign rdata[gi*BUS_W +: BUS_W] = word_mem[gi];
    end

endmodule

// File: rtl/l1i_mau.sv
// L1I miss access unit: fetches one cache line as NBEAT single-outstanding
// bus reads and hands the assembled line back with a one-cycle ack.
module l1i_mau
    import l1i_mau_pkg::*;
#(
    parameter int unsigned ADDR_W = L1_ADDR_W,
    parameter int unsigned LINE_W = L1_LINE_W,
    parameter int unsigned BUS_W  = L1_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mau_req_val,
    input  logic [ADDR_W-1:0] mau_req_addr,
    output logic              mau_req_ack,
    output logic [LINE_W-1:0] mau_ack_data,
    output logic              mem_req_val,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ack,
    input  logic              mem_rsp_val,
    input  logic [BUS_W-1:0]  mem_rsp_data
);

    localparam int unsigned       NBEAT      = l1_nbeat(LINE_W, BUS_W);
    localparam int unsigned       STRIDE     = l1_beat_stride(BUS_W);
    localparam int unsigned       BEAT_W     = $clog2(NBEAT);
    localparam int unsigned       LINE_BYTES = LINE_W / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NBEAT - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(LINE_BYTES - 1);

    mau_state_t        state_reg;
    mau_state_t        state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic              hold_reg;
    logic              fill_start;
    logic              beat_we;

    // hold_reg masks the request during the IDLE cycle right after DONE,
    // since L1I only drops mau_req_val once it has seen the ack.
    assign fill_start = (state_reg == IDLE) && mau_req_val && !hold_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fill_start)  state_next = REQ;
            REQ:     if (mem_req_ack) state_next = WAIT;
            WAIT:    if (mem_rsp_val) state_next = (beat_reg == LAST_BEAT) ? DONE : REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_val = 1'b0;
        mau_req_ack = 1'b0;
        beat_we     = 1'b0;
        case (state_reg)
            REQ:     mem_req_val = 1'b1;
            WAIT:    beat_we     = mem_rsp_val;
            DONE:    mau_req_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg <= '0;
            beat_reg <= '0;
            hold_reg <= 1'b0;
        end else begin
            hold_reg <= (state_reg == DONE);
            if (fill_start) begin
                base_reg <= mau_req_addr & ~OFF_MASK;
                beat_reg <= '0;
            end else if (beat_we && (beat_reg != LAST_BEAT)) begin
                beat_reg <= beat_reg + BEAT_W'(1);
            end
        end
    end

    // Base offset bits are zero, so the beat offset never carries into the tag.
    assign mem_req_addr = base_reg + (ADDR_W'(beat_reg) * ADDR_W'(STRIDE));

    l1i_mau_linebuf #(
        .LINE_W (LINE_W),
        .BUS_W  (BUS_W)
    ) u_linebuf (
        .clk   (clk),
        .we    (beat_we),
        .wbeat (beat_reg),
        .wdata (mem_rsp_data),
        .rdata (mau_ack_data)
    );

endmodule

// File: tb/tb_l1i_mau.sv
// Scoreboard bench for l1i_mau: a memory model serves beats, a monitor checks
// each delivered line and its latency against expectations queued at issue.
module tb_l1i_mau;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int BUS_W  = 32;
    localparam int NBEAT  = LINE_W / BUS_W;
    localparam int LBYTES = LINE_W / 8;
    localparam int WBYTES = BUS_W / 8;

    typedef struct {
        logic [LINE_W-1:0] data;
        int                start;
        int                lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              mau_req_val;
    logic [ADDR_W-1:0] mau_req_addr;
    logic              mau_req_ack;
    logic [LINE_W-1:0] mau_ack_data;
    logic              mem_req_val;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ack;
    logic              mem_rsp_val;
    logic [BUS_W-1:0]  mem_rsp_data;

    l1i_mau #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mau_req_val  (mau_req_val),
        .mau_req_addr (mau_req_addr),
        .mau_req_ack  (mau_req_ack),
        .mau_ack_data (mau_ack_data),
        .mem_req_val  (mem_req_val),
        .mem_req_addr (mem_req_addr),
        .mem_req_ack  (mem_req_ack),
        .mem_rsp_val  (mem_rsp_val),
        .mem_rsp_data (mem_rsp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    exp_t             sb_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [BUS_W-1:0]  mem_img [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] last_line = '0;

    // Memory model knobs (written by stimulus only).
    int ack_dly     = 0;
    int rsp_dly     = 0;
    int freeze_beat = -1;
    int stray_left  = 0;

    // Memory model state (written by the model only).
    bit                rsp_due   = 1'b0;
    int                rsp_wait  = 0;
    int                rsp_beat  = 0;
    logic [ADDR_W-1:0] rsp_addr  = '0;
    int                stall_cnt = 0;
    logic [ADDR_W-1:0] stall_addr = '0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 32'hDEAD_BEEF;
    endfunction

    // Memory: ack after ack_dly stall cycles, data rsp_dly cycles into WAIT.
    initial begin
        mem_req_ack  = 1'b0;
        mem_rsp_val  = 1'b0;
        mem_rsp_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ack = 1'b0;
            mem_rsp_val = 1'b0;
            if (rsp_due) begin
                if (rsp_beat != freeze_beat) begin
                    if (rsp_wait == 0) begin
                        mem_rsp_val  = 1'b1;
                        mem_rsp_data = mem_word(rsp_addr);
                        rsp_due      = 1'b0;
                    end else begin
                        rsp_wait--;
                    end
                end
            end else if (mem_req_val) begin
                if (stall_cnt > 0) chk("addr_stable", LINE_W'(mem_req_addr), LINE_W'(stall_addr));
                if (stall_cnt < ack_dly) begin
                    if (stall_cnt == 0) stall_addr = mem_req_addr;
                    stall_cnt++;
                end else begin
                    mem_req_ack = 1'b1;
                    stall_cnt   = 0;
                    chk("beat_pending", LINE_W'(addr_q.size() != 0), LINE_W'(1));
                    if (addr_q.size() != 0) chk("beat_addr", LINE_W'(mem_req_addr), LINE_W'(addr_q.pop_front()));
                    rsp_due  = 1'b1;
                    rsp_wait = rsp_dly;
                    rsp_addr = mem_req_addr;
                    rsp_beat = int'((mem_req_addr % LBYTES) / WBYTES);
                end
            end else if (stray_left > 0) begin
                mem_rsp_val  = 1'b1;
                mem_rsp_data = $urandom;
                stray_left--;
            end
        end
    end

    // Monitor: every ack must match the oldest queued expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && mau_req_ack) begin
            chk("ack_pending", LINE_W'(sb_q.size() != 0), LINE_W'(1));
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("ack_data", mau_ack_data, mon_e.data);
                if (mon_e.lat >= 0) chk("ack_latency", LINE_W'(cyc - mon_e.start), LINE_W'(mon_e.lat));
                $display("fill done at cycle %0d data %h", cyc, mau_ack_data);
            end
        end
    end

    task automatic push_beats(input logic [ADDR_W-1:0] base, input bit rnd, output logic [LINE_W-1:0] line);
        logic [ADDR_W-1:0] a;
        line = '0;
        for (int i = 0; i < NBEAT; i++) begin
            a = base + ADDR_W'(i * WBYTES);
            if (rnd) mem_img[a] = $urandom;
            line[i*BUS_W +: BUS_W] = mem_img[a];
            addr_q.push_back(a);
        end
    endtask

    task automatic do_fill(input logic [ADDR_W-1:0] addr, input int ad, input int rd, input bit rnd);
        exp_t              e;
        logic [ADDR_W-1:0] base;
        int                n;
        base    = addr & ~ADDR_W'(LBYTES - 1);
        ack_dly = ad;
        rsp_dly = rd;
        push_beats(base, rnd, e.data);
        e.lat   = 1 + NBEAT * (ad + rd + 2);
        e.start = cyc;
        sb_q.push_back(e);
        mau_req_val  = 1'b1;
        mau_req_addr = addr;
        n = 0;
        while (!mau_req_ack && n < 400) begin
            @(posedge clk); #1;
            n++;
            mau_req_addr = $urandom;
        end
        chk("ack_seen", LINE_W'(mau_req_ack), LINE_W'(1));
        last_line = e.data;
        // Hold val through the DONE cycle and the following IDLE cycle.
        @(posedge clk); #1;
        chk("no_refill_done", LINE_W'(mem_req_val), LINE_W'(0));
        mau_req_val = 1'b0;
        @(posedge clk); #1;
        chk("no_refill_idle", LINE_W'(mem_req_val), LINE_W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [LINE_W-1:0] part;
        int                n;
        rst          = 1'b1;
        mau_req_val  = 1'b0;
        mau_req_addr = '0;
        #3;
        chk("rst_ack",     LINE_W'(mau_req_ack),  LINE_W'(0));
        chk("rst_mem_val", LINE_W'(mem_req_val),  LINE_W'(0));
        chk("rst_mem_adr", LINE_W'(mem_req_addr), LINE_W'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait fill and the same line with a 3-cycle ack stall.
        mem_img[32'h1230] = 32'hA0;
        mem_img[32'h1234] = 32'hA1;
        mem_img[32'h1238] = 32'hA2;
        mem_img[32'h123C] = 32'hA3;
        do_fill(32'h0000_1230, 0, 0, 1'b0);
        chk("dir_line", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
        do_fill(32'h0000_1230, 3, 0, 1'b0);

        // Stray responses while idle must leave state and buffer alone.
        stray_left = 3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("stray_idle_val", LINE_W'(mem_req_val), LINE_W'(0));
            chk("stray_buf",      mau_ack_data, last_line);
        end

        // Reset during WAIT of beat 2; the late response then hits an idle unit.
        ack_dly     = 0;
        rsp_dly     = 0;
        freeze_beat = 2;
        push_beats(32'h3000, 1'b1, part);
        part[2*BUS_W +: 2*BUS_W] = last_line[2*BUS_W +: 2*BUS_W];
        mau_req_val  = 1'b1;
        mau_req_addr = 32'h3000;
        n = 0;
        while (!(rsp_due && rsp_beat == freeze_beat) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("freeze_reached", LINE_W'(n < 200), LINE_W'(1));
        @(posedge clk); #1;
        rst         = 1'b1;
        mau_req_val = 1'b0;
        #1;
        chk("mid_rst_val", LINE_W'(mem_req_val),  LINE_W'(0));
        chk("mid_rst_ack", LINE_W'(mau_req_ack),  LINE_W'(0));
        chk("mid_rst_adr", LINE_W'(mem_req_addr), LINE_W'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        addr_q.delete();
        freeze_beat = -1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", LINE_W'(mem_req_val), LINE_W'(0));
        end
        chk("post_rst_buf", mau_ack_data, part);
        do_fill(32'h0000_2000, 0, 0, 1'b1);

        // Top-of-memory line: beat addresses must not wrap into the tag.
        do_fill(32'hFFFF_FFF0, 1, 1, 1'b1);

        // Random lines, random stalls, random offset bits on the request.
        for (int t = 0; t < 25; t++) begin
            do_fill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained",   LINE_W'(sb_q.size()),   LINE_W'(0));
        chk("beat_drained", LINE_W'(addr_q.size()), LINE_W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
